// File: rtl/state_machine_moore.sv
`default_nettype none
// ============================================================================
// Module      : state_machine_moore
// Description : Moore FSM that flags two consecutive 1s on a serial input.
// Revision    : 1.0 - initial release
// ============================================================================
module state_machine_moore #(
    parameter int OVERLAP = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ONE  = 2'b01,
        DET  = 2'b10
    } state_t;

    state_t r_state;

    // The output flop is loaded with the decode of the next state so it
    // always matches r_state without a combinational path from in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            out     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= in ? ONE : IDLE;
                    out     <= 1'b0;
                end
                ONE: begin
                    r_state <= in ? DET : IDLE;
                    out     <= in;
                end
                DET: begin
                    if (!in) begin
                        r_state <= IDLE;
                        out     <= 1'b0;
                    end else if (OVERLAP != 0) begin
                        r_state <= DET;
                        out     <= 1'b1;
                    end else begin
                        r_state <= ONE;
                        out     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    out     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_state_machine_moore.sv
`default_nettype none
// ============================================================================
// Module      : tb_state_machine_moore
// Description : Directed and random checks of the "11" detector, both modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_state_machine_moore;

    logic clk;
    logic reset;
    logic in;
    logic out_ov;
    logic out_no;

    int n_checks;
    int n_fail;

    state_machine_moore #(.OVERLAP(1)) dut_ov (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .out   (out_ov)
    );

    state_machine_moore #(.OVERLAP(0)) dut_no (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .out   (out_no)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic e_ov, input logic e_no);
        n_checks++;
        assert (out_ov === e_ov) else begin
            n_fail++;
            $error("FAIL %s overlap: observed %b expected %b", tag, out_ov, e_ov);
        end
        n_checks++;
        assert (out_no === e_no) else begin
            n_fail++;
            $error("FAIL %s non-overlap: observed %b expected %b", tag, out_no, e_no);
        end
    endtask

    // Drive in just after the falling edge, sample just after the rising edge.
    task automatic step(input logic v, input logic e_ov, input logic e_no, input string tag);
        @(negedge clk);
        #1 in = v;
        @(posedge clk);
        #1;
        check(tag, e_ov, e_no);
    endtask

    int   run;
    logic v;
    logic m_ov;
    logic m_no;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        in       = 1'b1;

        #1 check("reset_init", 1'b0, 1'b0);
        @(posedge clk); #1 check("reset_hold0", 1'b0, 1'b0);
        @(posedge clk); #1 check("reset_hold1", 1'b0, 1'b0);

        // Release with in already 1: the first edge only reaches ONE.
        @(negedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 check("release_single1", 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, "release_to_idle");

        step(1'b0, 1'b0, 1'b0, "basic0");
        step(1'b1, 1'b0, 1'b0, "basic1");
        step(1'b1, 1'b1, 1'b1, "basic2");
        step(1'b0, 1'b0, 1'b0, "basic3");

        step(1'b1, 1'b0, 1'b0, "run0");
        step(1'b1, 1'b1, 1'b1, "run1");
        step(1'b1, 1'b1, 1'b0, "run2");
        step(1'b1, 1'b1, 1'b1, "run3");
        step(1'b0, 1'b0, 1'b0, "run_end");

        step(1'b1, 1'b0, 1'b0, "broken0");
        step(1'b0, 1'b0, 1'b0, "broken1");
        step(1'b1, 1'b0, 1'b0, "broken2");
        step(1'b0, 1'b0, 1'b0, "broken3");
        step(1'b1, 1'b0, 1'b0, "broken4");
        step(1'b0, 1'b0, 1'b0, "broken_end");

        step(1'b1, 1'b0, 1'b0, "async_pre0");
        step(1'b1, 1'b1, 1'b1, "async_pre1");
        #1 reset = 1'b0;
        #1 check("async_mid_cycle", 1'b0, 1'b0);
        in = 1'b0;
        @(negedge clk); #1 reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, "async_post0");
        step(1'b1, 1'b1, 1'b1, "async_post1");
        step(1'b0, 1'b0, 1'b0, "async_post_end");

        // Reference model driven by the length of the current run of 1s.
        run = 0;
        for (int i = 0; i < 10; i++) begin
            v = 1'($urandom_range(0, 1));
            run  = v ? run + 1 : 0;
            m_ov = (run >= 2);
            m_no = (run >= 2) && (run % 2 == 0);
            step(v, m_ov, m_no, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
